// File: rtl/control_sequencer.sv
// Instruction-cycle controller for the 16-bit accumulator datapath.
// Sequences fetch/decode/indirect/execute with run/halt control and an execute watchdog.
module control_sequencer #(
   parameter int FETCH_LAT = 2,
   parameter int IND_LAT   = 2,
   parameter int TIMEOUT   = 15,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             i_clr_reg,
   input  logic             i_start,
   input  logic [15:0]      i_ir,
   input  logic             i_ex_done,
   output logic             o_fetch,
   output logic             o_execute,
   output logic             o_is_ind,
   output logic             o_is_dir,
   output logic             o_add,
   output logic             o_load,
   output logic             o_store,
   output logic             o_branch,
   output logic             o_isz,
   output logic             o_clr_ac,
   output logic             o_clr_e,
   output logic             o_comp_ac,
   output logic             o_load_ac,
   output logic             o_cir_r,
   output logic             o_cir_l,
   output logic             o_inc_ac,
   output logic             o_halted,
   output logic             o_timeout,
   output logic             o_illegal,
   output logic [2:0]       o_state,
   output logic [CNT_W-1:0] o_instr_cnt
);

   localparam int WAIT_MAX = (FETCH_LAT > IND_LAT) ? FETCH_LAT : IND_LAT;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 2);
   localparam int WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      FWAIT  = 3'd2,
      DECODE = 3'd3,
      INDIR  = 3'd4,
      EXEC   = 3'd5,
      HALT   = 3'd6,
      FAULT  = 3'd7
   } state_t;

   // Strobe vector order, MSB first:
   // add, load, store, branch, isz, clr_ac, clr_e, comp_ac, load_ac, cir_r, cir_l, inc_ac
   function automatic logic [11:0] strobe_decode(input logic [15:0] ir);
      logic [11:0] s;
      s = '0;
      case (ir[14:12])
         3'b001:  s[11] = 1'b1;
         3'b010:  s[10] = 1'b1;
         3'b011:  s[9]  = 1'b1;
         3'b100:  s[8]  = 1'b1;
         3'b110:  s[7]  = 1'b1;
         3'b101:  s[3]  = 1'b1;
         3'b111: begin
            if (!ir[15] && ir != 16'h7001) begin
               if (ir[11])      s[6] = 1'b1;
               else if (ir[10]) s[5] = 1'b1;
               else if (ir[9])  s[4] = 1'b1;
               else if (ir[7])  s[2] = 1'b1;
               else if (ir[6])  s[1] = 1'b1;
               else if (ir[5])  s[0] = 1'b1;
            end
         end
         default: s = '0;
      endcase
      return s;
   endfunction

   function automatic logic is_mem(input logic [15:0] ir);
      return (ir[14:12] == 3'b001) || (ir[14:12] == 3'b010) || (ir[14:12] == 3'b011) ||
             (ir[14:12] == 3'b100) || (ir[14:12] == 3'b110);
   endfunction

   state_t            state_reg, state_next;
   logic [15:0]       ir_reg, ir_next;
   logic [WAIT_W-1:0] wait_reg, wait_next;
   logic [WD_W-1:0]   wd_reg, wd_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              illegal_next;

   logic [11:0]       stb_reg, stb_next;
   logic              fetch_reg, fetch_next;
   logic              execute_reg, execute_next;
   logic              is_ind_reg, is_ind_next;
   logic              is_dir_reg, is_dir_next;
   logic              halted_reg, halted_next;
   logic              timeout_reg, timeout_next;
   logic              illegal_reg;

   logic [11:0]       dec_stb;

   assign dec_stb = strobe_decode(i_ir);

   always_comb begin
      state_next   = state_reg;
      ir_next      = ir_reg;
      wait_next    = wait_reg;
      wd_next      = wd_reg;
      cnt_next     = cnt_reg;
      illegal_next = 1'b0;
      case (state_reg)
         IDLE, HALT: begin
            if (i_start) state_next = FETCH;
         end
         FETCH: begin
            if (FETCH_LAT == 0) begin
               state_next = DECODE;
            end else begin
               state_next = FWAIT;
               wait_next  = WAIT_W'(FETCH_LAT);
            end
         end
         FWAIT: begin
            // The counter is loaded with FETCH_LAT, so FWAIT lasts FETCH_LAT cycles.
            if (wait_reg <= WAIT_W'(1)) state_next = DECODE;
            else                        wait_next  = wait_reg - WAIT_W'(1);
         end
         DECODE: begin
            ir_next = i_ir;
            if (i_ir == 16'h7001) begin
               state_next = HALT;
               cnt_next   = cnt_reg + CNT_W'(1);
            end else if (is_mem(i_ir) && i_ir[15]) begin
               state_next = INDIR;
               wait_next  = WAIT_W'(IND_LAT);
            end else if (dec_stb != '0) begin
               state_next = EXEC;
               wd_next    = '0;
            end else begin
               // NOP or unsupported opcode: retire without executing.
               state_next   = FETCH;
               cnt_next     = cnt_reg + CNT_W'(1);
               illegal_next = !(i_ir[14:12] == 3'b111 && !i_ir[15]);
            end
         end
         INDIR: begin
            if (wait_reg == '0) begin
               state_next = EXEC;
               wd_next    = '0;
            end else begin
               wait_next = wait_reg - WAIT_W'(1);
            end
         end
         EXEC: begin
            if (i_ex_done) begin
               state_next = FETCH;
               cnt_next   = cnt_reg + CNT_W'(1);
            end else if (wd_reg == WD_W'(TIMEOUT - 1)) begin
               state_next = FAULT;
            end else begin
               wd_next = wd_reg + WD_W'(1);
            end
         end
         FAULT: state_next = FAULT;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state and next ir, so they line up with o_state.
   always_comb begin
      fetch_next   = (state_next == FETCH);
      execute_next = (state_next == EXEC);
      stb_next     = execute_next ? strobe_decode(ir_next) : '0;
      is_dir_next  = execute_next && is_mem(ir_next);
      is_ind_next  = (state_next == INDIR) && (state_reg != INDIR);
      halted_next  = (state_next == HALT);
      timeout_next = (state_next == FAULT);
   end

   always_ff @(posedge clk) begin
      if (i_clr_reg) begin
         state_reg   <= IDLE;
         ir_reg      <= '0;
         wait_reg    <= '0;
         wd_reg      <= '0;
         cnt_reg     <= '0;
         stb_reg     <= '0;
         fetch_reg   <= 1'b0;
         execute_reg <= 1'b0;
         is_ind_reg  <= 1'b0;
         is_dir_reg  <= 1'b0;
         halted_reg  <= 1'b0;
         timeout_reg <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ir_reg      <= ir_next;
         wait_reg    <= wait_next;
         wd_reg      <= wd_next;
         cnt_reg     <= cnt_next;
         stb_reg     <= stb_next;
         fetch_reg   <= fetch_next;
         execute_reg <= execute_next;
         is_ind_reg  <= is_ind_next;
         is_dir_reg  <= is_dir_next;
         halted_reg  <= halted_next;
         timeout_reg <= timeout_next;
         illegal_reg <= illegal_next;
      end
   end

   assign o_fetch     = fetch_reg;
   assign o_execute   = execute_reg;
   assign o_is_ind    = is_ind_reg;
   assign o_is_dir    = is_dir_reg;
   assign o_add       = stb_reg[11];
   assign o_load      = stb_reg[10];
   assign o_store     = stb_reg[9];
   assign o_branch    = stb_reg[8];
   assign o_isz       = stb_reg[7];
   assign o_clr_ac    = stb_reg[6];
   assign o_clr_e     = stb_reg[5];
   assign o_comp_ac   = stb_reg[4];
   assign o_load_ac   = stb_reg[3];
   assign o_cir_r     = stb_reg[2];
   assign o_cir_l     = stb_reg[1];
   assign o_inc_ac    = stb_reg[0];
   assign o_halted    = halted_reg;
   assign o_timeout   = timeout_reg;
   assign o_illegal   = illegal_reg;
   assign o_state     = state_reg;
   assign o_instr_cnt = cnt_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: table vectors, random instructions
// against a rule-level model, plus timeout, mid-execute reset and counter wrap sequences.
module tb_control_sequencer;

   localparam int P_EXEC = 0;
   localparam int P_IND  = 1;
   localparam int P_HALT = 2;
   localparam int P_ILL  = 3;
   localparam int P_NOP  = 4;

   logic        clk = 1'b0;
   logic        i_clr_reg, i_start, i_ex_done, start_w, ex_done_w;
   logic [15:0] i_ir;
   logic        o_fetch, o_execute, o_is_ind, o_is_dir;
   logic        o_add, o_load, o_store, o_branch, o_isz;
   logic        o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac;
   logic        o_halted, o_timeout, o_illegal;
   logic [2:0]  o_state;
   logic [15:0] o_instr_cnt;
   logic [11:0] strobes;

   // Narrow-counter instance for the wrap check.
   logic        w_fetch, w_execute, w_is_ind, w_is_dir;
   logic        w_add, w_load, w_store, w_branch, w_isz;
   logic        w_clr_ac, w_clr_e, w_comp_ac, w_load_ac, w_cir_r, w_cir_l, w_inc_ac;
   logic        w_halted, w_timeout, w_illegal;
   logic [2:0]  w_state;
   logic [1:0]  w_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   assign strobes = {o_add, o_load, o_store, o_branch, o_isz, o_clr_ac, o_clr_e,
                     o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac};

   control_sequencer dut (
      .clk(clk), .i_clr_reg(i_clr_reg), .i_start(i_start), .i_ir(i_ir), .i_ex_done(i_ex_done),
      .o_fetch(o_fetch), .o_execute(o_execute), .o_is_ind(o_is_ind), .o_is_dir(o_is_dir),
      .o_add(o_add), .o_load(o_load), .o_store(o_store), .o_branch(o_branch), .o_isz(o_isz),
      .o_clr_ac(o_clr_ac), .o_clr_e(o_clr_e), .o_comp_ac(o_comp_ac), .o_load_ac(o_load_ac),
      .o_cir_r(o_cir_r), .o_cir_l(o_cir_l), .o_inc_ac(o_inc_ac),
      .o_halted(o_halted), .o_timeout(o_timeout), .o_illegal(o_illegal),
      .o_state(o_state), .o_instr_cnt(o_instr_cnt)
   );

   control_sequencer #(.FETCH_LAT(0), .CNT_W(2)) dut_w (
      .clk(clk), .i_clr_reg(i_clr_reg), .i_start(start_w), .i_ir(i_ir), .i_ex_done(ex_done_w),
      .o_fetch(w_fetch), .o_execute(w_execute), .o_is_ind(w_is_ind), .o_is_dir(w_is_dir),
      .o_add(w_add), .o_load(w_load), .o_store(w_store), .o_branch(w_branch), .o_isz(w_isz),
      .o_clr_ac(w_clr_ac), .o_clr_e(w_clr_e), .o_comp_ac(w_comp_ac), .o_load_ac(w_load_ac),
      .o_cir_r(w_cir_r), .o_cir_l(w_cir_l), .o_inc_ac(w_inc_ac),
      .o_halted(w_halted), .o_timeout(w_timeout), .o_illegal(w_illegal),
      .o_state(w_state), .o_instr_cnt(w_cnt)
   );

   typedef struct {
      logic [15:0] ir;
      int          path;
      logic [11:0] strb;
      bit          dir;
      int          dly;
   } vec_t;

   typedef struct {
      int          path;
      logic [11:0] strb;
      bit          dir;
   } exp_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Instruction rules: which path an instruction takes and which strobe it fires.
   function automatic exp_t model(input logic [15:0] ir);
      exp_t e;
      int   op;
      int   reg_bit[6] = '{11, 10, 9, 7, 6, 5};
      int   reg_idx[6] = '{6, 5, 4, 2, 1, 0};
      bit   found;
      op = int'(ir[14:12]);
      e.path = P_EXEC;
      e.strb = '0;
      e.dir  = 1'b0;
      if (ir == 16'h7001) begin
         e.path = P_HALT;
      end else if (op == 0) begin
         e.path = P_ILL;
      end else if (op == 7) begin
         if (ir[15]) begin
            e.path = P_ILL;
         end else begin
            found = 1'b0;
            for (int i = 0; i < 6; i++) begin
               if (!found && ir[reg_bit[i]]) begin
                  e.strb[reg_idx[i]] = 1'b1;
                  found = 1'b1;
               end
            end
            if (!found) e.path = P_NOP;
         end
      end else if (op == 5) begin
         e.strb[3] = 1'b1;
      end else begin
         case (op)
            1: e.strb[11] = 1'b1;
            2: e.strb[10] = 1'b1;
            3: e.strb[9]  = 1'b1;
            4: e.strb[8]  = 1'b1;
            default: e.strb[7] = 1'b1;
         endcase
         e.dir  = 1'b1;
         e.path = ir[15] ? P_IND : P_EXEC;
      end
      return e;
   endfunction

   // Starts with the DUT sampled in FETCH; dly=0 means never signal done (expect FAULT).
   task automatic run_instr(input logic [15:0] ir, input int path, input logic [11:0] strb,
                            input bit dir, input int dly);
      int n;
      $display("txn ir=%04h path=%0d dly=%0d cnt=%0d", ir, path, dly, exp_cnt);
      i_ir = ir;
      chk("fetch_state", o_state, 1);
      chk("fetch_pulse", o_fetch, 1);
      step();
      chk("fwait1_state", o_state, 2);
      chk("fetch_drop", o_fetch, 0);
      chk("illegal_drop", o_illegal, 0);
      step();
      chk("fwait2_state", o_state, 2);
      step();
      chk("decode_state", o_state, 3);
      chk("decode_strobes", strobes, 0);
      step();
      if (path == P_HALT) begin
         exp_cnt++;
         chk("halt_state", o_state, 6);
         chk("halt_flag", o_halted, 1);
         chk("halt_exec", o_execute, 0);
         chk("halt_cnt", o_instr_cnt, 32'(exp_cnt[15:0]));
      end else if (path == P_ILL || path == P_NOP) begin
         exp_cnt++;
         chk("retire_state", o_state, 1);
         chk("retire_fetch", o_fetch, 1);
         chk("illegal_flag", o_illegal, (path == P_ILL) ? 1 : 0);
         chk("retire_exec", o_execute, 0);
         chk("retire_cnt", o_instr_cnt, 32'(exp_cnt[15:0]));
      end else begin
         if (path == P_IND) begin
            chk("indir_state", o_state, 4);
            chk("indir_pulse", o_is_ind, 1);
            chk("indir_exec", o_execute, 0);
            step();
            chk("indir_w1", o_state, 4);
            chk("indir_drop", o_is_ind, 0);
            step();
            chk("indir_w2", o_state, 4);
            step();
         end
         chk("exec_state", o_state, 5);
         chk("exec_flag", o_execute, 1);
         chk("exec_strobes", strobes, 32'(strb));
         chk("exec_dir", o_is_dir, 32'(dir));
         chk("exec_ind", o_is_ind, 0);
         n = (dly == 0) ? 15 : dly;
         for (int k = 1; k <= n; k++) begin
            chk("exec_hold", {o_state, strobes}, {3'd5, strb});
            if (k == dly) i_ex_done = 1'b1;
            step();
            i_ex_done = 1'b0;
         end
         if (dly == 0) begin
            chk("fault_state", o_state, 7);
            chk("fault_flag", o_timeout, 1);
            chk("fault_exec", o_execute, 0);
            chk("fault_strobes", strobes, 0);
         end else begin
            exp_cnt++;
            chk("done_state", o_state, 1);
            chk("done_fetch", o_fetch, 1);
            chk("done_strobes", strobes, 0);
            chk("done_exec", o_execute, 0);
            chk("done_cnt", o_instr_cnt, 32'(exp_cnt[15:0]));
         end
      end
   endtask

   task automatic leave_halt();
      i_ex_done = 1'b1;
      step();
      i_ex_done = 1'b0;
      chk("halt_ignores_done", o_state, 6);
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      chk("halt_restart", o_state, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      vec_t tbl[20];
      exp_t e;
      logic [15:0] r;
      int   sel;
      bit   reached;

      tbl[0]  = '{16'h2123, P_EXEC, 12'h400, 1'b1, 3};
      tbl[1]  = '{16'h9456, P_IND,  12'h800, 1'b1, 2};
      tbl[2]  = '{16'h7A00, P_EXEC, 12'h040, 1'b0, 1};
      tbl[3]  = '{16'h5012, P_EXEC, 12'h008, 1'b0, 4};
      tbl[4]  = '{16'h7001, P_HALT, 12'h000, 1'b0, 0};
      tbl[5]  = '{16'h0123, P_ILL,  12'h000, 1'b0, 0};
      tbl[6]  = '{16'h7000, P_NOP,  12'h000, 1'b0, 0};
      tbl[7]  = '{16'hF020, P_ILL,  12'h000, 1'b0, 0};
      tbl[8]  = '{16'hD000, P_EXEC, 12'h008, 1'b0, 2};
      tbl[9]  = '{16'h3456, P_EXEC, 12'h200, 1'b1, 15};
      tbl[10] = '{16'hC789, P_IND,  12'h100, 1'b1, 1};
      tbl[11] = '{16'h6001, P_EXEC, 12'h080, 1'b1, 5};
      tbl[12] = '{16'h7600, P_EXEC, 12'h020, 1'b0, 1};
      tbl[13] = '{16'h72E0, P_EXEC, 12'h010, 1'b0, 1};
      tbl[14] = '{16'h70E0, P_EXEC, 12'h004, 1'b0, 2};
      tbl[15] = '{16'h7060, P_EXEC, 12'h002, 1'b0, 1};
      tbl[16] = '{16'h7020, P_EXEC, 12'h001, 1'b0, 1};
      tbl[17] = '{16'h7010, P_NOP,  12'h000, 1'b0, 0};
      tbl[18] = '{16'hE001, P_IND,  12'h080, 1'b1, 3};
      tbl[19] = '{16'h8000, P_ILL,  12'h000, 1'b0, 0};

      i_clr_reg = 1'b1; i_start = 1'b0; i_ex_done = 1'b0; i_ir = '0;
      start_w = 1'b0; ex_done_w = 1'b0;
      repeat (3) step();
      chk("reset_state", o_state, 0);
      chk("reset_outputs", {strobes, o_fetch, o_execute, o_is_ind, o_is_dir,
                            o_halted, o_timeout, o_illegal}, 0);
      chk("reset_cnt", o_instr_cnt, 0);
      i_clr_reg = 1'b0;
      i_ex_done = 1'b1;
      step();
      i_ex_done = 1'b0;
      chk("idle_ignores_done", o_state, 0);
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      chk("idle_start", o_state, 1);

      foreach (tbl[i]) begin
         run_instr(tbl[i].ir, tbl[i].path, tbl[i].strb, tbl[i].dir, tbl[i].dly);
         if (tbl[i].path == P_HALT) leave_halt();
      end

      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 7));
         r = 16'($urandom);
         if (sel == 0)      r = 16'h7001;
         else if (sel <= 2) r = {4'h7, r[11:0]};
         e = model(r);
         run_instr(r, e.path, e.strb, e.dir, int'($urandom_range(1, 15)));
         if (e.path == P_HALT) leave_halt();
      end

      // Reset while executing.
      i_ir = 16'h2123;
      reached = 1'b0;
      for (int k = 0; k < 12 && !reached; k++) begin
         step();
         if (o_state == 3'd5) reached = 1'b1;
      end
      chk("reach_exec", 32'(reached), 1);
      step();
      i_clr_reg = 1'b1;
      step();
      i_clr_reg = 1'b0;
      exp_cnt = 0;
      chk("midexec_reset_state", o_state, 0);
      chk("midexec_reset_outputs", {strobes, o_execute, o_is_dir, o_fetch}, 0);
      chk("midexec_reset_cnt", o_instr_cnt, 0);

      // Watchdog expiry, then FAULT is sticky.
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      run_instr(16'h2123, P_EXEC, 12'h400, 1'b1, 0);
      i_start = 1'b1;
      i_ex_done = 1'b1;
      step();
      step();
      i_start = 1'b0;
      i_ex_done = 1'b0;
      chk("fault_sticky_state", o_state, 7);
      chk("fault_sticky_flag", o_timeout, 1);
      i_clr_reg = 1'b1;
      step();
      i_clr_reg = 1'b0;
      chk("fault_clear", {o_state, o_timeout}, 0);

      // Counter wrap on a 2-bit instance: 3 retires reach all-ones, 2 more give 1.
      i_ir = 16'h7001;
      for (int n = 1; n <= 5; n++) begin
         start_w = 1'b1;
         step();
         start_w = 1'b0;
         reached = 1'b0;
         for (int k = 0; k < 10 && !reached; k++) begin
            step();
            if (w_state == 3'd6) reached = 1'b1;
         end
         chk("wrap_halt_reached", 32'(reached), 1);
         if (n == 3) chk("wrap_allones", w_cnt, 3);
         if (n == 5) chk("wrap_result", w_cnt, 1);
         $display("txn wrap retire=%0d cnt=%0d", n, w_cnt);
      end
      chk("main_idle_during_wrap", o_state, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Instruction-cycle controller for the 16-bit accumulator datapath. Drives the datapath's fetch, indirect, execute and opcode strobes, and consumes its IR and ex_done outputs.
- Sequences fetch -> decode -> (indirect) -> execute -> fetch. Provides run/halt control and an execute watchdog.

Parameters:
FETCH_LAT, 2, wait cycles between the o_fetch pulse and the cycle in which i_ir is sampled
IND_LAT, 2, wait cycles after the o_is_ind pulse before EXEC
TIMEOUT, 15, maximum EXEC cycles without i_ex_done before FAULT
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  clock; all state changes on the rising edge
i_clr_reg  input  1  reset, synchronous, active-high
i_start  input  1  leave IDLE/HALT; level sampled only in those states
i_ir  input  16  instruction from datapath o_ir
i_ex_done  input  1  from datapath o_ex_done
o_fetch  output  1  to datapath i_fetch
o_execute  output  1  to datapath i_execute
o_is_ind  output  1  to datapath i_is_ind
o_is_dir  output  1  to datapath i_is_dir
o_add, o_load, o_store, o_branch, o_isz  output  1 each  memory-reference strobes
o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac  output  1 each  register-reference strobes
o_halted  output  1  high in HALT
o_timeout  output  1  high in FAULT
o_illegal  output  1  one-cycle pulse on an unsupported opcode
o_state  output  3  current state encoding
o_instr_cnt  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- States: IDLE=0, FETCH=1, FWAIT=2, DECODE=3, INDIR=4, EXEC=5, HALT=6, FAULT=7.
- Reset: state=IDLE, ir_q=0, wait/watchdog counters=0, o_instr_cnt=0. All strobes, o_halted, o_timeout and o_illegal are 0.
- Reset mid-operation aborts immediately: outputs take these values in the cycle after reset is sampled.
- Outputs are Moore: decoded from the state register and the latched ir_q only. No input reaches an output combinationally.
- IDLE: i_start=1 -> FETCH.
- FETCH: o_fetch=1 for exactly 1 cycle -> FWAIT, with the wait counter loaded to FETCH_LAT.
- FWAIT: decrements each cycle; at 0 -> DECODE. FETCH_LAT=0 means DECODE follows FETCH directly.
- DECODE: latch i_ir into ir_q. Fields: I=ir[15], op=ir[14:12].
- Decode map:
  - op 001 ADD, 010 LDA, 011 STA, 100 BUN, 110 ISZ: memory reference.
  - op 101: LDI, which asserts o_load_ac; I is ignored.
  - op 111 with I=0: register reference, priority bit11 CLA > bit10 CLE > bit9 CMA > bit7 CIR > bit6 CIL > bit5 INC. Only the highest set bit is strobed.
  - ir==16'h7001: HLT.
- DECODE transitions:
  - HLT -> HALT; o_instr_cnt is incremented.
  - Memory reference with I=1 -> INDIR.
  - Other supported instruction -> EXEC.
  - Register reference with no listed bit set: NOP; -> FETCH, o_instr_cnt incremented.
  - op 000, or op 111 with I=1: o_illegal=1 for 1 cycle; -> FETCH, o_instr_cnt incremented.
- INDIR: o_is_ind=1 on the first cycle only. Then wait IND_LAT cycles -> EXEC.
- EXEC:
  - o_execute=1 and exactly one opcode strobe, held for the whole state. o_is_dir=1 for memory references (direct or after indirect), 0 otherwise.
  - The watchdog clears on entry and increments each cycle.
  - i_ex_done=1 -> FETCH and o_instr_cnt+1; the strobes drop in the next cycle.
  - Watchdog reaches TIMEOUT with i_ex_done=0 -> FAULT.
  - If i_ex_done=1 in the same cycle the watchdog expires, done wins.
- i_ex_done is ignored in every state except EXEC.
- HALT: o_halted=1, all strobes 0. i_start=1 -> FETCH.
- FAULT: o_timeout=1, all strobes 0, i_start ignored. Exit only via i_clr_reg.
- Invariant: at most one opcode strobe is high in any cycle, and opcode strobes are high only while o_execute=1.

Test Plan:
1. Reset, i_start=1, i_ir=16'h2123 (LDA direct) -> o_fetch 1 cycle, FWAIT 2 cycles, DECODE 1 cycle, then EXEC with o_execute=o_load=o_is_dir=1. i_ex_done after 3 cycles -> o_instr_cnt 0->1, o_fetch high 1 cycle later.
2. i_ir=16'h9456 (ADD indirect) -> INDIR with o_is_ind=1 for 1 cycle, 2 wait cycles, then EXEC with o_add=o_is_dir=1 and o_is_ind=0.
3. i_ir=16'h7A00 -> EXEC with only o_clr_ac=1 (o_comp_ac=0). i_ir=16'h5012 -> o_load_ac=1, o_is_dir=0.
4. i_ir=16'h7001 -> HALT: o_halted=1, o_execute never asserted, o_instr_cnt+1. i_start pulse -> FETCH. i_ir=16'h0123 -> o_illegal 1-cycle pulse, no EXEC, next FETCH.
5. EXEC with i_ex_done held 0 -> FAULT after 15 cycles: o_timeout=1, strobes 0, o_state=7; i_start ignored. i_ex_done=1 exactly on cycle 15 -> FETCH, not FAULT.
6. i_clr_reg=1 during EXEC -> next cycle o_state=0, all strobes 0, o_instr_cnt=0. Preset the counter near 16'hFFFF and retire 2 instructions -> wraps to 16'h0001.
